pipelined_csel_adder: RTL and testbench
=======================================

Name: pipelined_csel_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor. It is the successor to the fixed-width combinational segment adders in the Adders library.
- The operand is split into NSEG = WIDTH/SEG_W segments. One segment is resolved per pipeline stage, using a precomputed carry-select pair muxed by the incoming carry.
- Operands enter through a valid/ready handshake and results leave through one, with full backpressure, so the block drops into streaming datapaths.

Parameters:
- WIDTH, 32, operand/sum width in bits. Must be a multiple of SEG_W, otherwise elaboration fails.
- SEG_W, 8, segment width. One segment is resolved per pipeline stage; NSEG = WIDTH/SEG_W, and NSEG must be ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand transfer valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add mode only).
- sub  in  1  1 = compute A-B, 0 = compute A+B+cin.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out; in subtract mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - While rst_n = 0 at a rising edge, all stage valid bits clear, and out_valid, sum, cout and ovf are driven to 0.
  - in_ready is combinational and reads 1 after reset.
- Operand preparation: when sub = 1, B is inverted and the effective carry-in is forced to 1; the cin port is ignored. When sub = 0, B is used as-is with carry-in = cin.
- Pipeline structure:
  - Stages 0..NSEG-1 each hold a valid bit, the carry into the next segment, the completed low sum segments, and the unprocessed high operand bits.
  - Stage k computes sum segment k as follows: precompute s0/c0 (carry-in 0) and s1/c1 (carry-in 1) from a[k], b[k], then select with the carry from stage k-1. Stage 0 selects with the effective carry-in.
- Handshake (bubble-collapsing):
  - Per stage, ready_k = !v_k || ready_{k+1}.
  - ready_NSEG = out_ready.
  - in_ready = ready_0.
  - Stage k loads from stage k-1 (or from the inputs for k = 0) when ready_k. Its valid bit becomes the upstream valid: in_valid for stage 0, v_{k-1} otherwise.
- Outputs:
  - out_valid = v_{NSEG-1}. sum, cout and ovf are registered in the last stage.
  - Outputs hold stable while out_valid = 1 and out_ready = 0.
- Latency: with no stall, an operand accepted at edge e appears at the outputs after edge e+NSEG-1, i.e. NSEG edges counting the accepting edge.
- Throughput: 1 result per cycle when out_ready = 1. Simultaneous accept-in and drain-out in the same cycle is legal at full occupancy.
- Capacity: NSEG transactions in flight. in_ready falls only when all stages are valid and out_ready = 0.
- Ordering: results emerge strictly in acceptance order; there is no reordering and no drop.
- Flags:
  - cout is the carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR cout. The carry into the top bit is captured inside the last stage's segment.
- Reset mid-operation: all in-flight transactions are discarded and no partial result is emitted. The first post-reset acceptance behaves as from idle.
- NSEG = 1: a single registered carry-select stage with latency 1.

Decomposition:
- Package pipelined_csel_adder_pkg:
  - localparam helper for NSEG.
  - Stage-record layout constants: widths of the carry, sum-so-far and remaining-operand fields.
- Sub-module csel_segment: purely combinational. Inputs are a SEG_W-bit a and b plus a carry select. Outputs are the selected sum, carry-out, and carry into the segment MSB (used for ovf). Internally it uses two ripple FA chains.
- The top level instantiates NSEG csel_segment copies plus the stage registers and handshake logic.

Test Plan:
- WIDTH=32, SEG_W=8, out_ready = 1. Add 0xFFFFFFFF + 0x00000001, cin = 0 → sum = 0x00000000, cout = 1, ovf = 0, out_valid exactly 4 edges after accept.
- Add 0x7FFFFFFF + 0x00000001, cin = 0 → sum = 0x80000000, cout = 0, ovf = 1. Also add 0x12345678 + 0x0F0F0F0F, cin = 1 → sum = 0x21436588, cout = 0.
- sub = 1, A = 5, B = 7 → sum = 0xFFFFFFFE, cout = 0, ovf = 0. sub = 1, A = 0x80000000, B = 1 → sum = 0x7FFFFFFF, cout = 1, ovf = 1.
- Backpressure: hold out_ready = 0 and offer 6 back-to-back operands → exactly 4 accepted, then in_ready = 0. Release out_ready → results drain in order at 1 per cycle, remaining 2 accepted, no loss or duplication.
- Streaming: 100 random operand pairs with random in_valid/out_ready gaps → every result matches the model, in order. With continuous valid/ready, sustained throughput is 1 per cycle.
- Reset: drive rst_n = 0 for 1 edge while 3 transactions are in flight → out_valid = 0, sum/cout/ovf = 0, in_ready = 1, no stale result emitted afterwards. Also repeat the first scenario with WIDTH=7, SEG_W=7.

Source files
------------

// File: rtl/pipelined_csel_adder_pkg.sv
// pipelined_csel_adder_pkg: segment count and stage-record field widths
package pipelined_csel_adder_pkg;
  localparam int CARRY_W = 1;
  function automatic int nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction
  function automatic int done_w(input int k, input int seg_w);
    return (k + 1) * seg_w;
  endfunction
  function automatic int rem_w(input int width, input int k, input int seg_w);
    return width - (k + 1) * seg_w;
  endfunction
endpackage

// File: rtl/pipelined_csel_adder_csel_segment.sv
// csel_segment: one carry-select segment built from two ripple chains
module csel_segment #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             cm
);
  logic [SEG_W-1:0] s0, s1;
  logic [SEG_W:0] k0, k1;
  always_comb begin
    k0[0] = 1'b0;
    k1[0] = 1'b1;
    for (int i = 0; i < SEG_W; i++) begin
      s0[i] = a[i] ^ b[i] ^ k0[i];
      s1[i] = a[i] ^ b[i] ^ k1[i];
      k0[i+1] = (a[i] & b[i]) | (k0[i] & (a[i] ^ b[i]));
      k1[i+1] = (a[i] & b[i]) | (k1[i] & (a[i] ^ b[i]));
    end
  end
  assign s  = ci ? s1 : s0;
  assign co = ci ? k1[SEG_W] : k0[SEG_W];
  assign cm = ci ? k1[SEG_W-1] : k0[SEG_W-1];
endmodule

// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: valid/ready pipelined carry-select adder/subtractor, one segment per stage
module pipelined_csel_adder
  import pipelined_csel_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSEG = nseg(WIDTH, SEG_W);
  if (WIDTH % SEG_W != 0 || WIDTH < SEG_W) begin : g_bad_width
    $error("WIDTH must be a positive multiple of SEG_W");
  end
  logic [NSEG-1:0] v_q, c_q, up_v, up_c, seg_c;
  logic [NSEG:0] rdy;
  logic [WIDTH-1:0] s_q [NSEG], a_q [NSEG], b_q [NSEG];
  logic [WIDTH-1:0] up_s [NSEG], up_a [NSEG], up_b [NSEG];
  logic [SEG_W-1:0] seg_s [NSEG];
  logic seg_m [NSEG];
  logic ovf_q;
  always_comb begin
    rdy[NSEG] = out_ready;
    for (int k = NSEG - 1; k >= 0; k--) rdy[k] = !v_q[k] || rdy[k+1];
  end
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    if (k == 0) begin : g_in
      assign up_v[k] = in_valid;
      assign up_c[k] = sub | cin;
      assign up_s[k] = '0;
      assign up_a[k] = a;
      assign up_b[k] = sub ? ~b : b;
    end else begin : g_pipe
      assign up_v[k] = v_q[k-1];
      assign up_c[k] = c_q[k-1];
      assign up_s[k] = s_q[k-1];
      assign up_a[k] = a_q[k-1];
      assign up_b[k] = b_q[k-1];
    end
    csel_segment #(.SEG_W(SEG_W)) u_seg (
      .a  (up_a[k][k*SEG_W +: SEG_W]),
      .b  (up_b[k][k*SEG_W +: SEG_W]),
      .ci (up_c[k]),
      .s  (seg_s[k]),
      .co (seg_c[k]),
      .cm (seg_m[k])
    );
  end
  // each stage advances only when its slot is free or its occupant moves on
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (rdy[k]) begin
          v_q[k] <= up_v[k];
          c_q[k] <= seg_c[k];
          s_q[k] <= up_s[k] | (WIDTH'(seg_s[k]) << (k * SEG_W));
          a_q[k] <= up_a[k];
          b_q[k] <= up_b[k];
          if (k == NSEG - 1) ovf_q <= seg_m[k] ^ seg_c[k];
        end
      end
    end
  end
  assign in_ready  = rdy[0];
  assign out_valid = v_q[NSEG-1];
  assign sum       = s_q[NSEG-1];
  assign cout      = c_q[NSEG-1];
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb_pipelined_csel_adder: directed vectors, backpressure, streaming and reset checks
module tb_pipelined_csel_adder;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0, out_valid, out_ready = 1'b1, cout, ovf;
  logic [W-1:0] a = '0, b = '0, sum;
  logic in_valid7 = 1'b0, in_ready7, cin7 = 1'b0, sub7 = 1'b0, out_valid7, cout7, ovf7;
  logic [6:0] a7 = '0, b7 = '0, sum7;

  pipelined_csel_adder #(.WIDTH(W), .SEG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );
  pipelined_csel_adder #(.WIDTH(7), .SEG_W(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7), .a(a7), .b(b7),
    .cin(cin7), .sub(sub7), .out_valid(out_valid7), .out_ready(1'b1), .sum(sum7),
    .cout(cout7), .ovf(ovf7)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic cin, sub;
    logic [W-1:0] s;
    logic co, ov;
  } vec_t;
  vec_t vt [9];
  int checks = 0, errors = 0;
  int n_acc = 0, n_drn = 0;
  logic [W+1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    logic [W-1:0] yy;
    logic [W:0] r;
    yy = s ? ~y : y;
    r = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s | c};
    return {r[W-1:0], r[W], (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1])};
  endfunction

  task automatic cyc(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic ic, input logic is, input logic ordy);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; cin = ic; sub = is; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_result: got sum=%0h with nothing outstanding", sum);
      end else chk("stream_result", {sum, cout, ovf}, exp_q.pop_front());
      n_drn++;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(ia, ib, ic, is));
      n_acc++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub; out_ready = 1'b1;
    #1 chk("vec_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("vec_latency", lat, 4);
    chk("vec_sum", sum, v.s);
    chk("vec_cout", cout, v.co);
    chk("vec_ovf", ovf, v.ov);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] da [6];
    int sent, lim;
    vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[2] = '{32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h21436588, 1'b0, 1'b0};
    vt[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[6] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0};
    vt[7] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vt[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid7", out_valid7, 0);
    chk("rst_in_ready7", in_ready7, 1);

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    for (int i = 0; i < 6; i++) da[i] = 32'h11111111 * (i + 1);
    n_acc = 0; n_drn = 0; sent = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, da[sent], 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);
      if (n_acc > sent) sent++;
    end
    chk("bp_accepted", n_acc, 4);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_hold_sum_a", sum, exp_q[0][W+1:2]);
    cyc(1'b1, da[sent], 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_sum_b", sum, exp_q[0][W+1:2]);
    chk("bp_still_blocked", n_acc, 4);
    lim = 0;
    while ((sent < 6 || exp_q.size() != 0) && lim < 50) begin
      cyc(sent < 6, da[sent < 6 ? sent : 0], 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1);
      if (n_acc > sent) sent++;
      lim++;
    end
    chk("bp_drained", n_drn, 6);
    chk("bp_queue_empty", exp_q.size(), 0);

    n_acc = 0; n_drn = 0;
    for (int i = 0; i < 24; i++) cyc(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
    chk("tp_accepted", n_acc, 24);
    chk("tp_drained", n_drn, 20);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("tp_queue_empty", exp_q.size(), 0);

    n_acc = 0; n_drn = 0; lim = 0;
    while (n_acc < 100 && lim < 3000) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      lim++;
    end
    lim = 0;
    while (exp_q.size() != 0 && lim < 20) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      lim++;
    end
    chk("rand_accepted", n_acc, 100);
    chk("rand_drained", n_drn, 100);

    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hA5A5A5A5 + i, 32'h12345678, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_out_valid", out_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    n_drn = 0;
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("no_stale_result", n_drn, 0);
    run_vec(vt[0]);

    @(negedge clk);
    in_valid7 = 1'b1; a7 = 7'h7F; b7 = 7'h01; cin7 = 1'b0; sub7 = 1'b0;
    @(negedge clk);
    in_valid7 = 1'b1; a7 = 7'h40; b7 = 7'h01; cin7 = 1'b0; sub7 = 1'b1;
    #1;
    chk("w7_out_valid", out_valid7, 1);
    chk("w7_sum", sum7, 7'h00);
    chk("w7_cout", cout7, 1);
    chk("w7_ovf", ovf7, 0);
    @(negedge clk);
    in_valid7 = 1'b0;
    #1;
    chk("w7_sub_sum", sum7, 7'h3F);
    chk("w7_sub_cout", cout7, 1);
    chk("w7_sub_ovf", ovf7, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
